parallel_rank_sorter: RTL

//  Parametrised single-pass rank sorter for window filters (median / alpha-trimmed mean).

---
 rtl/parallel_rank_sorter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/parallel_rank_sorter.sv
// rtl/parallel_rank_sorter.sv - single-pass DN-sample rank sorter with stable ties and original-index output
// Optional trimmed-sum stage: PARALLEL_RANK_SORTER_TRIM_SUM_EN
module parallel_rank_sorter #(
    parameter int DN   = 25,
    parameter int DW   = 8,
    parameter int IW   = $clog2(DN),
    parameter int TRIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW*DN-1:0]     in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW*DN-1:0]     out_data,
    output logic [IW*DN-1:0]     out_index,
    output logic [DW+IW-1:0]     out_trim_sum
);

    if (DN < 2) begin : g_dn_chk
        $error("parallel_rank_sorter: DN must be at least 2");
    end
    if (2 * TRIM >= DN) begin : g_trim_chk
        $error("parallel_rank_sorter: 2*TRIM must be less than DN");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_RANK,
        S_PERM,
        S_SUM,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0]    r_data [DN];
    logic             r_desc;
    logic [DN-1:0]    r_cmp  [DN];
    logic [DN-1:0]    w_cmp  [DN];
    logic [IW-1:0]    r_rank [DN];
    logic [IW-1:0]    w_rank [DN];
    logic [DW*DN-1:0] r_out_data;
    logic [IW*DN-1:0] r_out_index;
    logic             r_out_valid;

    // c[i][j]=1 means sample j sorts before sample i; the index tiebreak keeps ties stable
    always_comb begin
        w_cmp = '{default: '0};
        for (int i = 0; i < DN; i++) begin
            for (int j = 0; j < DN; j++) begin
                if (i != j) begin
                    if (r_desc)
                        w_cmp[i][j] = (r_data[j] > r_data[i]) ||
                                      ((r_data[j] == r_data[i]) && (j < i));
                    else
                        w_cmp[i][j] = (r_data[j] < r_data[i]) ||
                                      ((r_data[j] == r_data[i]) && (j < i));
                end
            end
        end
    end

    always_comb begin
        w_rank = '{default: '0};
        for (int i = 0; i < DN; i++) begin
            for (int j = 0; j < DN; j++) begin
                w_rank[i] = w_rank[i] + IW'(r_cmp[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_CMP;
            S_CMP:  w_next = S_RANK;
            S_RANK: w_next = S_PERM;
`ifdef PARALLEL_RANK_SORTER_TRIM_SUM_EN
            S_PERM: w_next = S_SUM;
            S_SUM:  w_next = S_HOLD;
`else
            S_PERM: w_next = S_HOLD;
`endif
            S_HOLD: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef PARALLEL_RANK_SORTER_TRIM_SUM_EN
    logic [DW+IW-1:0] r_trim_sum;
    logic [DW+IW-1:0] w_trim_sum;

    always_comb begin
        w_trim_sum = '0;
        for (int r = TRIM; r < DN - TRIM; r++) begin
            w_trim_sum = w_trim_sum + (DW+IW)'(r_out_data[r*DW +: DW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_trim_sum <= '0;
        else if (r_state == S_SUM)
            r_trim_sum <= w_trim_sum;
    end

    assign out_trim_sum = r_trim_sum;
`else
    assign out_trim_sum = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '{default: '0};
            r_desc      <= 1'b0;
            r_cmp       <= '{default: '0};
            r_rank      <= '{default: '0};
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < DN; i++) r_data[i] <= in_data[i*DW +: DW];
                        r_desc <= in_desc;
                    end
                end
                S_CMP:  r_cmp  <= w_cmp;
                S_RANK: r_rank <= w_rank;
                S_PERM: begin
                    // ranks are a permutation, so every output slot is overwritten
                    for (int i = 0; i < DN; i++) begin
                        r_out_data[r_rank[i]*DW +: DW]  <= r_data[i];
                        r_out_index[r_rank[i]*IW +: IW] <= IW'(i);
                    end
`ifndef PARALLEL_RANK_SORTER_TRIM_SUM_EN
                    r_out_valid <= 1'b1;
`endif
                end
`ifdef PARALLEL_RANK_SORTER_TRIM_SUM_EN
                S_SUM:  r_out_valid <= 1'b1;
`endif
                S_HOLD: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;

endmodule
